// File: rtl/neuron_input_loader_pkg.sv
// Shared constants and types for the fp32 neuron input path.
package neuron_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned N_INPUTS   = 37;
  localparam int unsigned NEURON_LAT = 7;

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } loader_state_t;

  // Width of a frame slot index; a one-word frame still needs a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/neuron_input_loader_if.sv
// Word-serial input handshake into the neuron input loader.
interface neuron_input_loader_if #(
  parameter int unsigned DATA_W = neuron_pkg::DATA_W
);

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/neuron_input_loader_delay.sv
// Fixed-latency delay of a single-bit strobe; DEPTH = 0 is a straight wire.
module valid_delay_line #(
  parameter int unsigned DEPTH = neuron_pkg::NEURON_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign out = in;
    end else begin : g_sr
      logic [DEPTH-1:0] r_sr;

      // Shift the strobe one stage per cycle; reset flushes in-flight pulses.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sr <= '0;
        end else begin
          r_sr[0] <= in;
          for (int unsigned i = 1; i < DEPTH; i++) begin
            r_sr[i] <= r_sr[i-1];
          end
        end
      end

      assign out = r_sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/neuron_input_loader.sv
// Serial-to-parallel frame assembler feeding the 37-input fp32 neuron.
// Words are collected in a shadow buffer; only complete, correctly sized
// frames are committed to the held-stable parallel output bus.
module neuron_input_loader #(
  parameter int unsigned N_INPUTS   = neuron_pkg::N_INPUTS,
  parameter int unsigned DATA_W     = neuron_pkg::DATA_W,
  parameter int unsigned NEURON_LAT = neuron_pkg::NEURON_LAT
) (
  input  logic                     clk,
  input  logic                     rst,
  neuron_input_loader_if.slave     s_if,
  output logic [DATA_W-1:0]        frame_out [N_INPUTS],
  output logic                     frame_valid,
  output logic                     out_valid,
  output logic                     err_len,
  output logic [15:0]              frame_cnt
);

  import neuron_pkg::*;

  localparam int unsigned IDX_W = idx_width(N_INPUTS);

  loader_state_t     r_state;
  loader_state_t     w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic              w_ready;
  logic              w_accept;
  logic              w_idx_last;
  logic              w_wr;
  logic              w_commit;
  logic              w_err;
  logic              w_out_valid;

  logic [DATA_W-1:0] r_shadow    [N_INPUTS];
  logic [DATA_W-1:0] r_frame_out [N_INPUTS];
  logic              r_frame_valid;
  logic              r_err_len;
  logic [15:0]       r_frame_cnt;

  // No backpressure exists: the loader is ready whenever it is out of reset.
  assign w_ready    = ~rst;
  assign w_accept   = s_if.s_valid & w_ready;
  assign w_idx_last = (r_idx == IDX_W'(N_INPUTS - 1));

  // Frame-length FSM: classify each accepted word as store, commit or error.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_wr        = 1'b0;
    w_commit    = 1'b0;
    w_err       = 1'b0;
    unique case (r_state)
      FILL: begin
        if (w_accept) begin
          if (w_idx_last) begin
            w_idx_nxt = '0;
            if (s_if.s_last) begin
              w_commit = 1'b1;
            end else begin
              w_err       = 1'b1;
              w_state_nxt = DRAIN;
            end
          end else if (s_if.s_last) begin
            w_err     = 1'b1;
            w_idx_nxt = '0;
          end else begin
            w_wr      = 1'b1;
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (w_accept && s_if.s_last) begin
          w_state_nxt = FILL;
          w_idx_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = FILL;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // FSM state and slot index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Shadow buffer holds slots 0..N-2; the final word bypasses it at commit.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_shadow[r_idx] <= s_if.s_data;
    end
  end

  // Parallel output bus, frame strobe, length error strobe and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_INPUTS; i++) begin
        r_frame_out[i] <= '0;
      end
      r_frame_valid <= 1'b0;
      r_err_len     <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_frame_valid <= w_commit;
      r_err_len     <= w_err;
      if (w_commit) begin
        for (int unsigned i = 0; i + 1 < N_INPUTS; i++) begin
          r_frame_out[i] <= r_shadow[i];
        end
        r_frame_out[N_INPUTS-1] <= s_if.s_data;
        r_frame_cnt             <= r_frame_cnt + 16'd1;
      end
    end
  end

  valid_delay_line #(
    .DEPTH (NEURON_LAT)
  ) u_valid_delay (
    .clk (clk),
    .rst (rst),
    .in  (r_frame_valid),
    .out (w_out_valid)
  );

  assign s_if.s_ready = w_ready;
  assign frame_out    = r_frame_out;
  assign frame_valid  = r_frame_valid;
  assign out_valid    = w_out_valid;
  assign err_len      = r_err_len;
  assign frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_neuron_input_loader.sv
// Scoreboard bench for neuron_input_loader: expected frames are queued when
// good frames are driven and popped when frame_valid is observed.
module tb_neuron_input_loader;

  localparam int unsigned N   = 37;
  localparam int unsigned LAT = 7;
  localparam int unsigned DW  = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  neuron_input_loader_if #(.DATA_W(DW)) s_if  ();
  neuron_input_loader_if #(.DATA_W(DW)) s_if1 ();

  logic [DW-1:0] frame_out  [N];
  logic          frame_valid;
  logic          out_valid;
  logic          err_len;
  logic [15:0]   frame_cnt;

  logic [DW-1:0] frame_out1 [1];
  logic          frame_valid1;
  logic          out_valid1;
  logic          err_len1;
  logic [15:0]   frame_cnt1;

  neuron_input_loader #(
    .N_INPUTS   (N),
    .DATA_W     (DW),
    .NEURON_LAT (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_if        (s_if),
    .frame_out   (frame_out),
    .frame_valid (frame_valid),
    .out_valid   (out_valid),
    .err_len     (err_len),
    .frame_cnt   (frame_cnt)
  );

  neuron_input_loader #(
    .N_INPUTS   (1),
    .DATA_W     (DW),
    .NEURON_LAT (0)
  ) dut1 (
    .clk         (clk),
    .rst         (rst),
    .s_if        (s_if1),
    .frame_out   (frame_out1),
    .frame_valid (frame_valid1),
    .out_valid   (out_valid1),
    .err_len     (err_len1),
    .frame_cnt   (frame_cnt1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fv_pulses = 0;
  int ov_pulses = 0;
  int err_pulses = 0;

  logic [DW-1:0] exp_words [$];
  logic [15:0]   exp_cnt   [$];
  int            fv_times  [$];
  logic [DW-1:0] model_frame [N];
  int            model_cnt = 0;

  // Scoreboard monitor, sampling 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst) begin
        if (frame_valid) begin
          fv_pulses++;
          fv_times.push_back(cyc);
          checks++;
          if (exp_words.size() < N) begin
            errors++;
            $display("FAIL sb_frame_valid: unexpected pulse, queued words %0d required %0d", exp_words.size(), N);
          end else begin
            for (int i = 0; i < N; i++) begin
              logic [DW-1:0] w;
              w = exp_words.pop_front();
              checks++;
              if (frame_out[i] !== w) begin
                errors++;
                $display("FAIL sb_frame_out[%0d]: got %h expected %h", i, frame_out[i], w);
              end
            end
          end
          checks++;
          if (exp_cnt.size() == 0) begin
            errors++;
            $display("FAIL sb_frame_cnt: got %h with no expected count queued", frame_cnt);
          end else begin
            logic [15:0] c;
            c = exp_cnt.pop_front();
            if (frame_cnt !== c) begin
              errors++;
              $display("FAIL sb_frame_cnt: got %h expected %h", frame_cnt, c);
            end
          end
        end
        if (out_valid) begin
          ov_pulses++;
          checks++;
          if (fv_times.size() == 0) begin
            errors++;
            $display("FAIL sb_out_valid: unexpected pulse at cycle %0d", cyc);
          end else begin
            int t;
            t = fv_times.pop_front();
            if (cyc - t != LAT) begin
              errors++;
              $display("FAIL sb_out_valid_lat: got %0d cycles expected %0d", cyc - t, LAT);
            end
          end
        end
        if (err_len) err_pulses++;
      end
    end
  end

  task automatic send_word(input logic [DW-1:0] d, input logic last, input int gap);
    bit ok;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      s_if.s_valid = 1'b0;
      s_if.s_data  = $urandom;
      s_if.s_last  = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    s_if.s_valid = 1'b1;
    s_if.s_data  = d;
    s_if.s_last  = last;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk);
      if (s_if.s_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: word %h not accepted, got ready %b expected 1", d, s_if.s_ready);
    end
    #1;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_good(input logic [DW-1:0] base, input int maxgap);
    model_cnt++;
    for (int i = 0; i < N; i++) begin
      exp_words.push_back(base + DW'(i));
      model_frame[i] = base + DW'(i);
    end
    exp_cnt.push_back(16'(model_cnt));
    for (int i = 0; i < N; i++) begin
      send_word(base + DW'(i), (i == N - 1), $urandom_range(0, maxgap));
    end
    checks++;
    if (frame_valid !== 1'b1) begin
      errors++;
      $display("FAIL commit_latency: frame_valid got %b expected 1", frame_valid);
    end
  endtask

  task automatic model_reset();
    exp_words.delete();
    exp_cnt.delete();
    fv_times.delete();
    model_cnt = 0;
    for (int i = 0; i < N; i++) model_frame[i] = '0;
  endtask

  task automatic test_reset();
    bit bad;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (s_if.s_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", s_if.s_ready); end
    checks++;
    if (frame_valid !== 1'b0) begin errors++; $display("FAIL rst_frame_valid: got %b expected 0", frame_valid); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (err_len !== 1'b0) begin errors++; $display("FAIL rst_err_len: got %b expected 0", err_len); end
    checks++;
    if (frame_cnt !== 16'h0000) begin errors++; $display("FAIL rst_frame_cnt: got %h expected 0000", frame_cnt); end
    bad = 1'b0;
    for (int i = 0; i < N; i++) if (frame_out[i] !== '0) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL rst_frame_out: got nonzero word expected all zero"); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (s_if.s_ready !== 1'b1) begin errors++; $display("FAIL ready_after_rst: got %b expected 1", s_if.s_ready); end
  endtask

  task automatic test_good_frame();
    int f0, o0, e0;
    f0 = fv_pulses; o0 = ov_pulses; e0 = err_pulses;
    send_good(32'h3F80_0000, 0);
    idle(LAT + 2);
    checks++;
    if (frame_cnt !== 16'd1) begin errors++; $display("FAIL good_cnt: got %0d expected 1", frame_cnt); end
    checks++;
    if (fv_pulses - f0 != 1) begin errors++; $display("FAIL good_fv_count: got %0d expected 1", fv_pulses - f0); end
    checks++;
    if (ov_pulses - o0 != 1) begin errors++; $display("FAIL good_ov_count: got %0d expected 1", ov_pulses - o0); end
    checks++;
    if (err_pulses != e0) begin errors++; $display("FAIL good_err: got %0d expected 0", err_pulses - e0); end
  endtask

  task automatic test_short_frame();
    int e0;
    bit bad;
    e0 = err_pulses;
    for (int i = 0; i <= 10; i++) send_word(32'h1111_0000 + DW'(i), (i == 10), 0);
    checks++;
    if (err_len !== 1'b1 || frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL short_err: got err_len %b frame_valid %b expected 1 0", err_len, frame_valid);
    end
    idle(2);
    bad = 1'b0;
    for (int i = 0; i < N; i++) if (frame_out[i] !== model_frame[i]) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL short_hold: got changed frame_out expected previous frame"); end
    send_good(32'h4000_0000, 0);
    idle(LAT + 2);
    checks++;
    if (err_pulses - e0 != 1) begin errors++; $display("FAIL short_err_count: got %0d expected 1", err_pulses - e0); end
    checks++;
    if (frame_cnt !== 16'(model_cnt)) begin errors++; $display("FAIL short_cnt: got %0d expected %0d", frame_cnt, model_cnt); end
  endtask

  task automatic test_long_frame();
    int e0;
    bit bad;
    e0 = err_pulses;
    for (int i = 0; i < 40; i++) begin
      send_word(32'h2222_0000 + DW'(i), (i == 39), 0);
      if (i == N - 1) begin
        checks++;
        if (err_len !== 1'b1) begin errors++; $display("FAIL long_err: got %b expected 1", err_len); end
      end else if (i > N - 1) begin
        checks++;
        if (err_len !== 1'b0 || frame_valid !== 1'b0) begin
          errors++;
          $display("FAIL long_drain: got err_len %b frame_valid %b expected 0 0", err_len, frame_valid);
        end
      end
    end
    idle(2);
    bad = 1'b0;
    for (int i = 0; i < N; i++) if (frame_out[i] !== model_frame[i]) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL long_hold: got changed frame_out expected previous frame"); end
    checks++;
    if (err_pulses - e0 != 1) begin errors++; $display("FAIL long_err_count: got %0d expected 1", err_pulses - e0); end
    send_good(32'h5000_0000, 0);
    idle(LAT + 2);
    checks++;
    if (frame_cnt !== 16'(model_cnt)) begin errors++; $display("FAIL long_cnt: got %0d expected %0d", frame_cnt, model_cnt); end
  endtask

  task automatic test_back_to_back();
    int f0, o0, e0;
    f0 = fv_pulses; o0 = ov_pulses; e0 = err_pulses;
    for (int k = 0; k < 3; k++) begin
      send_good(32'h6000_0000 + DW'(k << 8), (k == 0) ? 0 : 3);
    end
    idle(LAT + 3);
    checks++;
    if (fv_pulses - f0 != 3) begin errors++; $display("FAIL b2b_fv_count: got %0d expected 3", fv_pulses - f0); end
    checks++;
    if (ov_pulses - o0 != 3) begin errors++; $display("FAIL b2b_ov_count: got %0d expected 3", ov_pulses - o0); end
    checks++;
    if (err_pulses != e0) begin errors++; $display("FAIL b2b_err: got %0d expected 0", err_pulses - e0); end
  endtask

  task automatic test_reset_midframe();
    bit bad;
    int e0;
    send_good(32'h7000_0000, 0);
    for (int i = 0; i < 3; i++) send_word(32'h7100_0000 + DW'(i), 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    s_if.s_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    bad = 1'b0;
    for (int i = 0; i < N; i++) if (frame_out[i] !== '0) bad = 1'b1;
    checks++;
    if (bad || frame_cnt !== 16'h0 || frame_valid !== 1'b0 || out_valid !== 1'b0 || err_len !== 1'b0 || s_if.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: got cnt %h fv %b ov %b err %b rdy %b zero_bus %b expected 0 0 0 0 0 1",
               frame_cnt, frame_valid, out_valid, err_len, s_if.s_ready, !bad);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) send_word(32'h7200_0000 + DW'(i), 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    s_if.s_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (frame_cnt !== 16'h0 || frame_valid !== 1'b0 || err_len !== 1'b0) begin
      errors++;
      $display("FAIL midrst20: got cnt %h fv %b err %b expected 0 0 0", frame_cnt, frame_valid, err_len);
    end
    @(negedge clk);
    rst = 1'b0;
    e0 = err_pulses;
    send_good(32'h7300_0000, 0);
    idle(LAT + 2);
    checks++;
    if (frame_cnt !== 16'd1) begin errors++; $display("FAIL midrst_cnt: got %0d expected 1", frame_cnt); end
    checks++;
    if (err_pulses != e0) begin errors++; $display("FAIL midrst_err: got %0d expected 0", err_pulses - e0); end
  endtask

  task automatic test_cnt_wrap_n1();
    checks++;
    if (frame_cnt1 !== 16'h0) begin errors++; $display("FAIL n1_cnt_start: got %h expected 0000", frame_cnt1); end
    for (int i = 0; i < 65536; i++) begin
      @(negedge clk);
      s_if1.s_valid = 1'b1;
      s_if1.s_last  = 1'b1;
      s_if1.s_data  = DW'(i);
      @(posedge clk);
      #1;
      if (i == 0 || i == 65534 || i == 65535) begin
        logic [15:0] c;
        c = 16'(i + 1);
        checks++;
        if (frame_cnt1 !== c) begin errors++; $display("FAIL n1_cnt[%0d]: got %h expected %h", i, frame_cnt1, c); end
        checks++;
        if (frame_out1[0] !== DW'(i)) begin errors++; $display("FAIL n1_data[%0d]: got %h expected %h", i, frame_out1[0], DW'(i)); end
        checks++;
        if (frame_valid1 !== 1'b1 || out_valid1 !== 1'b1 || err_len1 !== 1'b0) begin
          errors++;
          $display("FAIL n1_strobes[%0d]: got fv %b ov %b err %b expected 1 1 0", i, frame_valid1, out_valid1, err_len1);
        end
      end
    end
    @(negedge clk);
    s_if1.s_valid = 1'b0;
  endtask

  initial begin
    #20_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    s_if.s_valid  = 1'b0;
    s_if.s_data   = '0;
    s_if.s_last   = 1'b0;
    s_if1.s_valid = 1'b0;
    s_if1.s_data  = '0;
    s_if1.s_last  = 1'b0;
    model_reset();
    test_reset();
    test_good_frame();
    test_short_frame();
    test_long_frame();
    test_back_to_back();
    test_reset_midframe();
    test_cnt_wrap_n1();
    idle(LAT + 2);
    checks++;
    if (exp_words.size() != 0 || fv_times.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d words %0d strobes pending expected 0 0", exp_words.size(), fv_times.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_input_loader.md
# neuron_input_loader

Serial-to-parallel input stage feeding the 37-input floating-point neuron. Accepts one IEEE-754 single-precision word per handshake and assembles a complete frame in a shadow buffer. On frame completion it commits the frame to a double-buffered, held-stable parallel output bus for the neuron. It also delays a frame strobe by the neuron's pipeline latency so downstream logic knows when the activation output belongs to the new frame.

## Interface

Parameters:
- N_INPUTS, 37, words per frame (neuron weights excluding bias)
- DATA_W, 32, word width (fp32 bit pattern, passed through unmodified)
- NEURON_LAT, 7, cycles from frame_out change to valid neuron output_out

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- s_data  in  DATA_W  input word
- s_valid  in  1  s_data valid
- s_last  in  1  marks final word of a frame; qualified by s_valid
- s_ready  out  1  loader can accept a word
- frame_out  out  DATA_W x N_INPUTS  unpacked array, index 0 = first word of frame; drives the neuron's input_in
- frame_valid  out  1  one-cycle pulse: frame_out just updated
- out_valid  out  1  frame_valid delayed NEURON_LAT cycles
- err_len  out  1  one-cycle pulse: frame length violation detected
- frame_cnt  out  16  count of committed frames, wraps 0xFFFF -> 0

## Operation

- Handshake: a word is accepted when s_valid && s_ready in the same cycle. s_data, s_valid and s_last may change freely when not accepted.
- State FILL:
  - Each accepted word is written to shadow[idx], then idx++. idx has width clog2(N_INPUTS) and starts at 0.
  - idx == N_INPUTS-1 and s_last = 1: good frame. Commit the whole shadow, with the current word at slot N_INPUTS-1, into frame_out. Pulse frame_valid, increment frame_cnt, idx <= 0, stay in FILL.
  - idx < N_INPUTS-1 and s_last = 1: short frame. Pulse err_len, discard the shadow, idx <= 0, stay in FILL. frame_out is unchanged.
  - idx == N_INPUTS-1 and s_last = 0: long frame. Pulse err_len, discard the shadow, go to DRAIN.
- State DRAIN:
  - Accept and discard words.
  - The accepted word with s_last = 1 moves the block to FILL with idx <= 0. No second err_len is raised.
- s_ready is 1 in FILL and DRAIN, and 0 while rst is high. There is no backpressure from the neuron: frame_out is held until the next good commit, so the neuron may evaluate the same frame repeatedly.
- frame_out changes only on a good commit. Partial frames are never visible on it.
- out_valid comes from an NEURON_LAT-deep shift register of frame_valid. Back-to-back frames produce one out_valid pulse per frame.

## Timing

- Reset values: s_ready 0, frame_out all zeros, frame_valid 0, out_valid 0 (shift register cleared), err_len 0, frame_cnt 0, idx 0, state FILL, shadow contents don't-care.
- The first cycle after rst deasserts has s_ready = 1.
- Commit latency: if the last word is accepted at edge k, frame_out and frame_valid update at edge k+1.
- out_valid asserts at edge k+1+NEURON_LAT.
- Minimum frame period is N_INPUTS cycles. A new frame's first word may be accepted in the same cycle frame_valid is high.
- err_len is registered and asserts the cycle after the offending word is accepted.
- Reset mid-frame: the partial frame is lost. frame_out returns to zeros. In-flight out_valid pulses are flushed.
- N_INPUTS = 1: every accepted word with s_last = 1 is a good frame.

## Structure

- Package neuron_pkg holds:
  - constants DATA_W = 32 and N_INPUTS = 37
  - typedef word_t = logic [DATA_W-1:0]
  - enum loader_state_t {FILL, DRAIN}
  - NEURON_LAT default, shared with the neuron wrapper
- Sub-module valid_delay_line (parameter DEPTH, ports clk, rst, in, out) implements the out_valid shift register. DEPTH = 0 is a wire.
- The shadow buffer and frame_out are plain register arrays. No RAM inference.

## Test plan

- Good frame: send 37 words 0x3F800000+i with s_last on word 36 -> the edge after the last accept, frame_out[i] = 0x3F800000+i, frame_valid pulses once, frame_cnt = 1. out_valid pulses 7 cycles after frame_valid.
- Short frame: s_last on word 10, then a good frame of words 0x40000000+i -> err_len pulses once, frame_cnt = 1, frame_out shows only 0x40000000+i values.
- Long frame: 40 words with s_last on word 39 -> err_len pulses after word 36, DRAIN discards words 37-39, frame_out unchanged. The next good frame commits.
- Back-to-back with s_valid toggling randomly over 3 frames -> 3 frame_valid pulses and 3 out_valid pulses, each 7 cycles apart from its frame_valid, with correct per-frame data.
- Reset after word 20 of a frame -> all outputs at reset values next cycle. The next 37-word frame commits with frame_cnt = 1 and no err_len.
- frame_cnt preloaded near wrap via 65536 frames (or forced) -> 0xFFFF then 0x0000.
